// File: rtl/dmem_wmon_pkg.sv
// Shared types and helpers for the data-memory write monitor.
package dmem_wmon_pkg;

  localparam int AW_DEF = 30;
  localparam int DW_DEF = 32;
  localparam int TSW    = 16;
  localparam logic [TSW-1:0] TS_MAX = 16'hFFFF;

  // One completed store as seen by the result checker.
  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
    logic [TSW-1:0]    ts;
  } dmem_ev_t;

  // Little-endian store word into readable (most significant byte first) order.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/wmon_fifo.sv
// Synchronous event FIFO; pointers carry one extra wrap bit to tell full from empty.
module wmon_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 62
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign head_o  = mem_q[rd_q[PW-1:0]];

  // Caller only pushes when there is room or the head is leaving on the same edge.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i)             wr_d = wr_q + 1'b1;
    if (pop_i && !empty_o)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[PW-1:0]] <= din_i;
  end

endmodule

// File: rtl/dmem_write_monitor.sv
// Turns the CPU D-memory write port into one buffered event per completed store.
// Define DMEM_WMON_TIMESTAMP_EN to stamp each event with the capture cycle.
module dmem_write_monitor
  import dmem_wmon_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  input  logic          mem_wen,
  input  logic          mem_stall,
  output logic          ev_valid,
  input  logic          ev_ready,
  output logic [AW-1:0] ev_addr,
  output logic [DW-1:0] ev_data,
  output logic [15:0]   ev_time,
  output logic [7:0]    drop_cnt,
  output logic          overflow
);

`ifdef DMEM_WMON_TIMESTAMP_EN
  localparam int EW = AW + DW + TSW;
`else
  localparam int EW = AW + DW;
`endif

  logic          cap, pop, push, drop, full, empty;
  logic [EW-1:0] din, head;
  logic [DW-1:0] swapped;
  logic [7:0]    drop_q, drop_d;
  logic          ovf_q, ovf_d;

  // A stalled store is still in flight; only the unstalled edge completes it.
  assign cap     = mem_wen && !mem_stall;
  assign pop     = ev_ready && !empty;
  assign push    = cap && (!full || pop);
  assign drop    = cap && full && !pop;
  assign swapped = bswap32(mem_wdata);

  always_comb begin
    drop_d = drop_q;
    ovf_d  = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef DMEM_WMON_TIMESTAMP_EN
  logic [TSW-1:0] cnt_q, cnt_d;

  assign cnt_d = (cnt_q == TS_MAX) ? cnt_q : cnt_q + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign din     = {mem_addr, swapped, cnt_q};
  assign ev_time = ev_valid ? head[TSW-1:0] : '0;
`else
  assign din     = {mem_addr, swapped};
  assign ev_time = '0;
`endif

  wmon_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .pop_i  (pop),
    .din_i  (din),
    .full_o (full),
    .empty_o(empty),
    .head_o (head)
  );

  // Outputs read zero while empty so reset and drained states look identical.
  assign ev_valid = !empty;
  assign ev_addr  = ev_valid ? head[EW-1 -: AW]    : '0;
  assign ev_data  = ev_valid ? head[EW-AW-1 -: DW] : '0;
  assign drop_cnt = drop_q;
  assign overflow = ovf_q;

endmodule
